spi_cmd_frame_decoder: RTL and testbench

Parametrised successor to the main control block. It assembles numbered SPI bytes into a 9-byte command frame, checks sequence, inter-byte timeout and XOR checksum, then decodes an opcode. The decoded frame becomes one-cycle-valid camera-I2C, camera-capture or hard-reset commands. It sits between the SPI slave interface and the camera interface / camera I2C blocks.

---
 rtl/spi_cmd_pkg.sv | 59 +++++
 rtl/spi_frame_assembler.sv | 146 ++++++++++++++
 rtl/spi_cmd_frame_decoder.sv | 165 ++++++++++++++++
 tb/tb_spi_cmd_frame_decoder.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared constants and types for the SPI command frame decoder.
// Holds opcodes, error codes, FSM state encoding, frame byte
// positions and the assembled-frame payload struct.
package spi_cmd_pkg;

  localparam int unsigned FRAME_BYTES = 9;

  // Frame byte positions
  localparam int unsigned IDX_OPCODE = 0;
  localparam int unsigned IDX_CFG    = 1;
  localparam int unsigned IDX_TS0    = 2;
  localparam int unsigned IDX_TS1    = 3;
  localparam int unsigned IDX_TS2    = 4;
  localparam int unsigned IDX_TS3    = 5;
  localparam int unsigned IDX_TRIG0  = 6;
  localparam int unsigned IDX_TRIG1  = 7;
  localparam int unsigned IDX_CSUM   = 8;

  // Bit positions inside the configuration byte
  localparam int unsigned CFG_CAM_LSB  = 4;
  localparam int unsigned CFG_RGB      = 3;
  localparam int unsigned CFG_COMP_LSB = 1;
  localparam int unsigned CFG_TRIG     = 0;

  // Opcodes
  localparam logic [7:0] OP_I2C        = 8'h01;
  localparam logic [7:0] OP_CAPTURE    = 8'h02;
  localparam logic [7:0] OP_HARD_RESET = 8'h03;

  // Error codes
  localparam logic [1:0] ERR_SEQ      = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;
  localparam logic [1:0] ERR_OPCODE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DECODE  = 2'd2
  } state_t;

  // Decoder command selected for the current cycle
  typedef enum logic [2:0] {
    CMD_NONE       = 3'd0,
    CMD_I2C        = 3'd1,
    CMD_CAPTURE    = 3'd2,
    CMD_HARD_RESET = 3'd3,
    CMD_ERROR      = 3'd4
  } cmd_t;

  // Assembled frame payload (checksum byte not retained)
  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  cfg;
    logic [31:0] ts;
    logic [15:0] idx;
  } frame_t;

endpackage

// File: rtl/spi_frame_assembler.sv
// Collects numbered SPI bytes into a frame buffer.
// Tracks expected byte number, inter-byte timeout and a running XOR.
// Ports:
//   i_clk, i_rst_n         clock, synchronous active-low reset
//   i_byte/i_valid/i_byte_num  incoming numbered byte
//   o_frame_done_c         high during the single DECODE cycle
//   o_seq_err_c            out-of-sequence byte seen this cycle
//   o_timeout_c            inter-byte timeout expires this cycle
//   o_checksum_ok_c        running XOR over all nine bytes is zero
//   o_busy_c               FSM not idle
//   o_frame                buffered frame payload
module spi_frame_assembler
  import spi_cmd_pkg::*;
#(
  parameter int unsigned BNUM_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_byte,
  input  logic              i_valid,
  input  logic [BNUM_W-1:0] i_byte_num,
  output logic              o_frame_done_c,
  output logic              o_seq_err_c,
  output logic              o_timeout_c,
  output logic              o_checksum_ok_c,
  output logic              o_busy_c,
  output frame_t            o_frame
);

  localparam int unsigned CNT_W     = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned BUF_IDX_W = $clog2(FRAME_BYTES - 1);
  localparam logic [BNUM_W-1:0] LAST_NUM = BNUM_W'(IDX_CSUM);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [FRAME_BYTES-2:0][7:0] r_buf;
  logic [BNUM_W-1:0]           r_expect;
  logic [CNT_W-1:0]            r_cnt;
  logic [7:0]                  r_xor;

  logic                 w_start;
  logic                 w_accept;
  logic                 w_seq_err;
  logic                 w_timeout;
  logic [BUF_IDX_W-1:0] w_wr_idx;

  assign w_wr_idx = i_byte_num[BUF_IDX_W-1:0];

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle event decode
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_seq_err   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      // DECODE lasts one cycle; a byte arriving then is handled as in IDLE
      ST_IDLE, ST_DECODE: begin
        w_state_nxt = ST_IDLE;
        if (i_valid) begin
          if (i_byte_num == '0) begin
            w_start     = 1'b1;
            w_state_nxt = ST_COLLECT;
          end else begin
            w_seq_err = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (i_valid) begin
          if (i_byte_num == '0) begin
            // Silent restart: this byte becomes the new opcode
            w_start = 1'b1;
          end else if (i_byte_num == r_expect) begin
            w_accept = 1'b1;
            if (r_expect == LAST_NUM) begin
              w_state_nxt = ST_DECODE;
            end
          end else begin
            w_seq_err   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Frame buffer, expected byte number and running XOR
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_buf    <= '0;
      r_expect <= '0;
      r_xor    <= '0;
    end else if (w_start) begin
      r_buf[IDX_OPCODE] <= i_byte;
      r_expect          <= BNUM_W'(1);
      r_xor             <= i_byte;
    end else if (w_accept) begin
      // Checksum byte only feeds the XOR
      if (i_byte_num != LAST_NUM) begin
        r_buf[w_wr_idx] <= i_byte;
      end
      r_expect <= r_expect + BNUM_W'(1);
      r_xor    <= r_xor ^ i_byte;
    end
  end

  // Inter-byte timeout counter, only runs while collecting
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_start || w_accept || (w_state_nxt != ST_COLLECT)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_frame_done_c  = (r_state == ST_DECODE);
  assign o_seq_err_c     = w_seq_err;
  assign o_timeout_c     = w_timeout;
  assign o_checksum_ok_c = (r_xor == 8'h00);
  assign o_busy_c        = (r_state != ST_IDLE);

  assign o_frame.opcode = r_buf[IDX_OPCODE];
  assign o_frame.cfg    = r_buf[IDX_CFG];
  assign o_frame.ts     = {r_buf[IDX_TS0], r_buf[IDX_TS1], r_buf[IDX_TS2], r_buf[IDX_TS3]};
  assign o_frame.idx    = {r_buf[IDX_TRIG0], r_buf[IDX_TRIG1]};

endmodule

// File: rtl/spi_cmd_frame_decoder.sv
// SPI command frame decoder: turns 9-byte numbered SPI frames into
// one-cycle camera-I2C, camera-capture or hard-reset commands, or an
// error pulse with a reason code.
// Ports:
//   sysClk, rst_n                    clock, synchronous active-low reset
//   spi_byte/spi_input_valid/spi_byte_num  numbered byte stream
//   cam_i2c_*                        I2C byte + valid pulse
//   compression/RGB/cam_id/timestamp/trigger/trigger_index + valid  capture
//   hard_reset_MCB                   hard-reset pulse
//   err_valid/err_code               rejected frame pulse + held reason
//   busy                             frame collection in progress
module spi_cmd_frame_decoder
  import spi_cmd_pkg::*;
#(
  parameter int unsigned TS_WIDTH    = 28,
  parameter int unsigned IDX_WIDTH   = 16,
  parameter int unsigned CAM_ID_W    = 1,
  parameter int unsigned BNUM_W      = 4,
  parameter bit          CHECKSUM_EN = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                 sysClk,
  input  logic                 rst_n,
  input  logic [7:0]           spi_byte,
  input  logic                 spi_input_valid,
  input  logic [BNUM_W-1:0]    spi_byte_num,
  output logic [7:0]           cam_i2c_byte_MCB,
  output logic                 cam_i2c_output_valid_MCB,
  output logic [1:0]           compression_MCB,
  output logic                 RGB_MCB,
  output logic [CAM_ID_W-1:0]  cam_id_MCB,
  output logic [TS_WIDTH-1:0]  timestamp_MCB,
  output logic                 trigger_MCB,
  output logic [IDX_WIDTH-1:0] trigger_index_MCB,
  output logic                 cam_interface_output_valid_MCB,
  output logic                 hard_reset_MCB,
  output logic                 err_valid,
  output logic [1:0]           err_code,
  output logic                 busy
);

  logic   w_frame_done;
  logic   w_seq_err;
  logic   w_timeout;
  logic   w_checksum_ok;
  logic   w_busy;
  frame_t w_frame;
  cmd_t   w_cmd;
  logic [1:0] w_err_code;
  logic   w_unused;

  logic [7:0]           r_i2c_byte;
  logic                 r_i2c_valid;
  logic [1:0]           r_comp;
  logic                 r_rgb;
  logic [CAM_ID_W-1:0]  r_cam_id;
  logic [TS_WIDTH-1:0]  r_ts;
  logic                 r_trig;
  logic [IDX_WIDTH-1:0] r_idx;
  logic                 r_cap_valid;
  logic                 r_hard_reset;
  logic                 r_err_valid;
  logic [1:0]           r_err_code;

  spi_frame_assembler #(
    .BNUM_W      (BNUM_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_assembler (
    .i_clk           (sysClk),
    .i_rst_n         (rst_n),
    .i_byte          (spi_byte),
    .i_valid         (spi_input_valid),
    .i_byte_num      (spi_byte_num),
    .o_frame_done_c  (w_frame_done),
    .o_seq_err_c     (w_seq_err),
    .o_timeout_c     (w_timeout),
    .o_checksum_ok_c (w_checksum_ok),
    .o_busy_c        (w_busy),
    .o_frame         (w_frame)
  );

  // Frame fields narrower than the payload leave some bits unread
  assign w_unused = ^{w_frame};

  // Pick one command per cycle; a completed frame outranks a
  // sequence error raised by a byte landing in the DECODE cycle
  always_comb begin
    w_cmd      = CMD_NONE;
    w_err_code = ERR_SEQ;
    if (w_frame_done) begin
      if (CHECKSUM_EN && !w_checksum_ok) begin
        w_cmd      = CMD_ERROR;
        w_err_code = ERR_CHECKSUM;
      end else begin
        case (w_frame.opcode)
          OP_I2C:        w_cmd = CMD_I2C;
          OP_CAPTURE:    w_cmd = CMD_CAPTURE;
          OP_HARD_RESET: w_cmd = CMD_HARD_RESET;
          default: begin
            w_cmd      = CMD_ERROR;
            w_err_code = ERR_OPCODE;
          end
        endcase
      end
    end else if (w_seq_err) begin
      w_cmd      = CMD_ERROR;
      w_err_code = ERR_SEQ;
    end else if (w_timeout) begin
      w_cmd      = CMD_ERROR;
      w_err_code = ERR_TIMEOUT;
    end
  end

  // Registered pulses and held command data
  always_ff @(posedge sysClk) begin
    if (!rst_n) begin
      r_i2c_byte   <= '0;
      r_i2c_valid  <= 1'b0;
      r_comp       <= '0;
      r_rgb        <= 1'b0;
      r_cam_id     <= '0;
      r_ts         <= '0;
      r_trig       <= 1'b0;
      r_idx        <= '0;
      r_cap_valid  <= 1'b0;
      r_hard_reset <= 1'b0;
      r_err_valid  <= 1'b0;
      r_err_code   <= '0;
    end else begin
      r_i2c_valid  <= (w_cmd == CMD_I2C);
      r_cap_valid  <= (w_cmd == CMD_CAPTURE);
      r_hard_reset <= (w_cmd == CMD_HARD_RESET);
      r_err_valid  <= (w_cmd == CMD_ERROR);
      if (w_cmd == CMD_I2C) begin
        r_i2c_byte <= w_frame.cfg;
      end
      if (w_cmd == CMD_CAPTURE) begin
        r_cam_id <= w_frame.cfg[CFG_CAM_LSB +: CAM_ID_W];
        r_rgb    <= w_frame.cfg[CFG_RGB];
        r_comp   <= w_frame.cfg[CFG_COMP_LSB +: 2];
        r_trig   <= w_frame.cfg[CFG_TRIG];
        r_ts     <= w_frame.ts[TS_WIDTH-1:0];
        r_idx    <= w_frame.idx[IDX_WIDTH-1:0];
      end
      if (w_cmd == CMD_ERROR) begin
        r_err_code <= w_err_code;
      end
    end
  end

  assign cam_i2c_byte_MCB               = r_i2c_byte;
  assign cam_i2c_output_valid_MCB       = r_i2c_valid;
  assign compression_MCB                = r_comp;
  assign RGB_MCB                        = r_rgb;
  assign cam_id_MCB                     = r_cam_id;
  assign timestamp_MCB                  = r_ts;
  assign trigger_MCB                    = r_trig;
  assign trigger_index_MCB              = r_idx;
  assign cam_interface_output_valid_MCB = r_cap_valid;
  assign hard_reset_MCB                 = r_hard_reset;
  assign err_valid                      = r_err_valid;
  assign err_code                       = r_err_code;
  assign busy                           = w_busy;

endmodule

// File: tb/tb_spi_cmd_frame_decoder.sv
// Self-checking bench for spi_cmd_frame_decoder: table of whole frames,
// directed multi-cycle sequences, and random traffic checked against a
// queue-based protocol model.
module tb_spi_cmd_frame_decoder;

  localparam int unsigned TS_WIDTH  = 28;
  localparam int unsigned IDX_WIDTH = 16;
  localparam int unsigned CAM_ID_W  = 1;
  localparam int unsigned BNUM_W    = 4;
  localparam int unsigned TMO       = 20;

  localparam int K_NONE = 0;
  localparam int K_I2C  = 1;
  localparam int K_CAP  = 2;
  localparam int K_HR   = 3;
  localparam int K_ERR  = 4;
  localparam int K_BAD  = 99;

  logic              sysClk;
  logic              rst_n;
  logic [7:0]        spi_byte;
  logic              spi_input_valid;
  logic [BNUM_W-1:0] spi_byte_num;

  logic [7:0]           cam_i2c_byte_MCB, nc_i2c_byte;
  logic                 cam_i2c_output_valid_MCB, nc_i2c_valid;
  logic [1:0]           compression_MCB, nc_comp;
  logic                 RGB_MCB, nc_rgb;
  logic [CAM_ID_W-1:0]  cam_id_MCB, nc_cam_id;
  logic [TS_WIDTH-1:0]  timestamp_MCB, nc_ts;
  logic                 trigger_MCB, nc_trig;
  logic [IDX_WIDTH-1:0] trigger_index_MCB, nc_idx;
  logic                 cam_interface_output_valid_MCB, nc_cap_valid;
  logic                 hard_reset_MCB, nc_hard_reset;
  logic                 err_valid, nc_err_valid;
  logic [1:0]           err_code, nc_err_code;
  logic                 busy, nc_busy;

  spi_cmd_frame_decoder #(
    .TS_WIDTH(TS_WIDTH), .IDX_WIDTH(IDX_WIDTH), .CAM_ID_W(CAM_ID_W),
    .BNUM_W(BNUM_W), .CHECKSUM_EN(1'b1), .TIMEOUT_CYC(TMO)
  ) dut (
    .sysClk(sysClk), .rst_n(rst_n), .spi_byte(spi_byte),
    .spi_input_valid(spi_input_valid), .spi_byte_num(spi_byte_num),
    .cam_i2c_byte_MCB(cam_i2c_byte_MCB), .cam_i2c_output_valid_MCB(cam_i2c_output_valid_MCB),
    .compression_MCB(compression_MCB), .RGB_MCB(RGB_MCB), .cam_id_MCB(cam_id_MCB),
    .timestamp_MCB(timestamp_MCB), .trigger_MCB(trigger_MCB),
    .trigger_index_MCB(trigger_index_MCB),
    .cam_interface_output_valid_MCB(cam_interface_output_valid_MCB),
    .hard_reset_MCB(hard_reset_MCB), .err_valid(err_valid), .err_code(err_code), .busy(busy)
  );

  spi_cmd_frame_decoder #(
    .TS_WIDTH(TS_WIDTH), .IDX_WIDTH(IDX_WIDTH), .CAM_ID_W(CAM_ID_W),
    .BNUM_W(BNUM_W), .CHECKSUM_EN(1'b0), .TIMEOUT_CYC(TMO)
  ) dut_nc (
    .sysClk(sysClk), .rst_n(rst_n), .spi_byte(spi_byte),
    .spi_input_valid(spi_input_valid), .spi_byte_num(spi_byte_num),
    .cam_i2c_byte_MCB(nc_i2c_byte), .cam_i2c_output_valid_MCB(nc_i2c_valid),
    .compression_MCB(nc_comp), .RGB_MCB(nc_rgb), .cam_id_MCB(nc_cam_id),
    .timestamp_MCB(nc_ts), .trigger_MCB(nc_trig), .trigger_index_MCB(nc_idx),
    .cam_interface_output_valid_MCB(nc_cap_valid),
    .hard_reset_MCB(nc_hard_reset), .err_valid(nc_err_valid), .err_code(nc_err_code), .busy(nc_busy)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  typedef struct {
    int         kind;
    logic [1:0] code;
    logic [7:0] b1;
    logic [31:0] ts;
    logic [15:0] idx;
  } ev_t;

  typedef struct {
    logic [63:0] f;      // bytes 0..7, byte 0 in the top bits
    logic [7:0]  mask;   // XORed into the correct checksum byte
    int          kind;
    logic [1:0]  code;
    int          nc_kind;
  } vec_t;

  logic [7:0] m_q[$];
  ev_t        exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int to_kind(input logic [3:0] p);
    case (p)
      4'b0000: return K_NONE;
      4'b1000: return K_I2C;
      4'b0100: return K_CAP;
      4'b0010: return K_HR;
      4'b0001: return K_ERR;
      default: return K_BAD;
    endcase
  endfunction

  function automatic logic [3:0] pulses();
    return {cam_i2c_output_valid_MCB, cam_interface_output_valid_MCB, hard_reset_MCB, err_valid};
  endfunction

  function automatic logic [3:0] nc_pulses();
    return {nc_i2c_valid, nc_cap_valid, nc_hard_reset, nc_err_valid};
  endfunction

  function automatic logic [63:0] all_outs();
    return {cam_i2c_byte_MCB, cam_i2c_output_valid_MCB, compression_MCB, RGB_MCB, cam_id_MCB,
            timestamp_MCB, trigger_MCB, trigger_index_MCB, cam_interface_output_valid_MCB,
            hard_reset_MCB, err_valid, err_code, busy};
  endfunction

  function automatic logic [63:0] nc_outs();
    return {nc_i2c_byte, nc_i2c_valid, nc_comp, nc_rgb, nc_cam_id, nc_ts, nc_trig, nc_idx,
            nc_cap_valid, nc_hard_reset, nc_err_valid, nc_err_code, nc_busy};
  endfunction

  task automatic push_ev(input int kind, input logic [1:0] code, input logic [7:0] b1,
                         input logic [31:0] ts, input logic [15:0] idx);
    ev_t e;
    e.kind = kind; e.code = code; e.b1 = b1; e.ts = ts; e.idx = idx;
    exp_q.push_back(e);
  endtask

  // Protocol model: bytes of the frame in progress live in m_q
  task automatic model_byte(input logic [7:0] b, input int n);
    logic [7:0] x;
    if (n == 0) begin
      m_q.delete();
      m_q.push_back(b);
    end else if (m_q.size() > 0 && n == m_q.size()) begin
      m_q.push_back(b);
      if (m_q.size() == 9) begin
        x = 8'h00;
        foreach (m_q[i]) x = x ^ m_q[i];
        if (x != 8'h00)        push_ev(K_ERR, 2'd2, 8'h0, 32'h0, 16'h0);
        else if (m_q[0] == 8'h01) push_ev(K_I2C, 2'd0, m_q[1], 32'h0, 16'h0);
        else if (m_q[0] == 8'h02) push_ev(K_CAP, 2'd0, m_q[1],
                                          {m_q[2], m_q[3], m_q[4], m_q[5]}, {m_q[6], m_q[7]});
        else if (m_q[0] == 8'h03) push_ev(K_HR, 2'd0, 8'h0, 32'h0, 16'h0);
        else                   push_ev(K_ERR, 2'd3, 8'h0, 32'h0, 16'h0);
        m_q.delete();
      end
    end else begin
      push_ev(K_ERR, 2'd0, 8'h0, 32'h0, 16'h0);
      m_q.delete();
    end
  endtask

  // Returns at the falling edge just after the byte was sampled
  task automatic send_byte(input logic [7:0] b, input int n);
    @(negedge sysClk);
    spi_byte        = b;
    spi_byte_num    = BNUM_W'(n);
    spi_input_valid = 1'b1;
    model_byte(b, n);
    @(negedge sysClk);
    spi_input_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] f, input logic [7:0] mask);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 8; i++) begin
      send_byte(f[63-8*i -: 8], i);
      x = x ^ f[63-8*i -: 8];
    end
    send_byte(x ^ mask, 8);
  endtask

  // Monitor: every pulse must match the next modelled event
  always @(negedge sysClk) begin : mon
    logic [3:0] p;
    int k;
    ev_t e;
    if (mon_en && rst_n) begin
      p = pulses();
      k = to_kind(p);
      if (k == K_BAD) begin
        chk("pulse_onehot", 64'($countones(p)), 64'd1);
      end else if (k != K_NONE) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 64'(k), 64'(K_NONE));
        end else begin
          e = exp_q.pop_front();
          chk("ev_kind", 64'(k), 64'(e.kind));
          if (k == e.kind) begin
            case (k)
              K_ERR: chk("ev_err_code", 64'(err_code), 64'(e.code));
              K_I2C: chk("ev_i2c_byte", 64'(cam_i2c_byte_MCB), 64'(e.b1));
              K_CAP: begin
                chk("ev_cam_id", 64'(cam_id_MCB), 64'((e.b1 / 16) % (1 << CAM_ID_W)));
                chk("ev_rgb", 64'(RGB_MCB), 64'((e.b1 / 8) % 2));
                chk("ev_comp", 64'(compression_MCB), 64'((e.b1 / 2) % 4));
                chk("ev_trig", 64'(trigger_MCB), 64'(e.b1 % 2));
                chk("ev_ts", 64'(timestamp_MCB), 64'(e.ts) % (64'd1 << TS_WIDTH));
                chk("ev_idx", 64'(trigger_index_MCB), 64'(e.idx) % (64'd1 << IDX_WIDTH));
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  vec_t vecs[7];

  initial begin
    int k;
    int r;
    int m;
    logic [63:0] f;
    logic [7:0]  mask;

    vecs[0] = '{64'h02A7FE6FA6361AAA, 8'h00, K_CAP, 2'd0, K_CAP};
    vecs[1] = '{64'h013C000000000000, 8'h00, K_I2C, 2'd0, K_I2C};
    vecs[2] = '{64'h02A7FE6FA6361AAA, 8'h01, K_ERR, 2'd2, K_CAP};
    vecs[3] = '{64'h0300000000000000, 8'h00, K_HR,  2'd0, K_HR};
    vecs[4] = '{64'h7F11223344556677, 8'h00, K_ERR, 2'd3, K_ERR};
    vecs[5] = '{64'h0259123456789ABC, 8'h00, K_CAP, 2'd0, K_CAP};
    vecs[6] = '{64'h013C000000000000, 8'h80, K_ERR, 2'd2, K_I2C};

    rst_n = 1'b0; spi_byte = 8'h00; spi_input_valid = 1'b0; spi_byte_num = '0;
    repeat (3) @(negedge sysClk);
    chk("reset_outputs", all_outs(), 64'd0);
    chk("reset_outputs_nc", nc_outs(), 64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Table of whole frames: exact 2-cycle latency and 1-cycle pulses
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].f, vecs[i].mask);
      chk($sformatf("vec%0d_no_early_pulse", i), 64'(pulses()), 64'd0);
      @(negedge sysClk);
      chk($sformatf("vec%0d_kind", i), 64'(to_kind(pulses())), 64'(vecs[i].kind));
      chk($sformatf("vec%0d_nc_kind", i), 64'(to_kind(nc_pulses())), 64'(vecs[i].nc_kind));
      if (vecs[i].kind == K_ERR)
        chk($sformatf("vec%0d_err_code", i), 64'(err_code), 64'(vecs[i].code));
      if (i == 0) begin
        chk("cap_cam_id", 64'(cam_id_MCB), 64'd0);
        chk("cap_rgb", 64'(RGB_MCB), 64'd0);
        chk("cap_comp", 64'(compression_MCB), 64'd3);
        chk("cap_trig", 64'(trigger_MCB), 64'd1);
        chk("cap_ts", 64'(timestamp_MCB), 64'h0E6FA636);
        chk("cap_idx", 64'(trigger_index_MCB), 64'h1AAA);
      end
      if (i == 1) chk("i2c_byte", 64'(cam_i2c_byte_MCB), 64'h3C);
      if (i == 2) chk("nc_cap_ts", 64'(nc_ts), 64'h0E6FA636);
      @(negedge sysClk);
      chk($sformatf("vec%0d_pulse_width", i), 64'(pulses()), 64'd0);
    end

    // Out-of-sequence byte number
    send_byte(8'h02, 0);
    send_byte(8'hA7, 1);
    send_byte(8'h11, 3);
    chk("seq_err_valid", 64'(err_valid), 64'd1);
    chk("seq_err_code", 64'(err_code), 64'd0);
    chk("seq_busy", 64'(busy), 64'd0);

    // Silent restart with byte number 0
    send_byte(8'h02, 0);
    send_byte(8'h55, 1);
    send_frame(vecs[0].f, 8'h00);
    chk("restart_no_early", 64'(pulses()), 64'd0);
    @(negedge sysClk);
    chk("restart_cap_valid", 64'(to_kind(pulses())), 64'(K_CAP));
    chk("restart_cap_comp", 64'(compression_MCB), 64'd3);

    // Inter-byte timeout
    for (int i = 0; i < 5; i++) send_byte(vecs[5].f[63-8*i -: 8], i);
    chk("timeout_busy_before", 64'(busy), 64'd1);
    push_ev(K_ERR, 2'd1, 8'h0, 32'h0, 16'h0);
    m_q.delete();
    k = 1;
    while (k <= 2 * TMO) begin
      @(negedge sysClk);
      if (err_valid) break;
      k++;
    end
    chk("timeout_cycles", 64'(k), 64'(TMO));
    chk("timeout_err_code", 64'(err_code), 64'd1);
    chk("timeout_busy_after", 64'(busy), 64'd0);

    // Reset in the middle of a frame
    for (int i = 0; i < 5; i++) send_byte(vecs[0].f[63-8*i -: 8], i);
    @(negedge sysClk);
    spi_byte = vecs[0].f[23:16]; spi_byte_num = BNUM_W'(5); spi_input_valid = 1'b1;
    rst_n = 1'b0;
    m_q.delete();
    @(negedge sysClk);
    spi_input_valid = 1'b0;
    rst_n = 1'b1;
    chk("midreset_outputs", all_outs(), 64'd0);
    chk("midreset_outputs_nc", nc_outs(), 64'd0);
    repeat (3) @(negedge sysClk);
    send_frame(vecs[1].f, 8'h00);
    @(negedge sysClk);
    chk("after_reset_i2c", 64'(to_kind(pulses())), 64'(K_I2C));

    // Random traffic against the model
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 99);
      if (r < 65) begin
        f = {$urandom(), $urandom()};
        case ($urandom_range(0, 3))
          0: f[63:56] = 8'h01;
          1: f[63:56] = 8'h02;
          2: f[63:56] = 8'h03;
          default: ;
        endcase
        mask = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        send_frame(f, mask);
      end else if (r < 85) begin
        k = $urandom_range(1, 8);
        for (int i = 0; i < k; i++) send_byte(8'($urandom()), i);
        m = $urandom_range(1, 15);
        if (m == k) m = (k % 15) + 1;
        send_byte(8'($urandom()), m);
      end else begin
        k = $urandom_range(1, 7);
        for (int i = 0; i < k; i++) send_byte(8'($urandom()), i);
      end
      repeat ($urandom_range(0, 3)) @(negedge sysClk);
    end

    repeat (5) @(negedge sysClk);
    chk("expected_events_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
